// File: rtl/acc_dual_16bit_pkg.sv
// -----------------------------------------------------------------------------
// acc_dual_16bit_pkg
// Shared constants and helpers for the dual-channel product accumulator.
//   DEF_ACC_WIDTH / DEF_NUM_TERMS / DEF_CNT_WIDTH : default build parameters
//   PROD_WIDTH                                    : width of incoming products
//   min_acc_width()                               : smallest accumulator width
//                                                   that cannot overflow for a
//                                                   given window length
// -----------------------------------------------------------------------------
package acc_dual_16bit_pkg;

  localparam int DEF_ACC_WIDTH = 24;
  localparam int DEF_NUM_TERMS = 9;
  localparam int DEF_CNT_WIDTH = 16;
  localparam int PROD_WIDTH    = 16;

  // A window of num_terms products plus the bias grows by at most
  // clog2(num_terms+1) bits over a single product.
  function automatic int min_acc_width(input int num_terms);
    return PROD_WIDTH + $clog2(num_terms + 1);
  endfunction

endpackage

// File: rtl/acc_dual_16bit_lane.sv
// -----------------------------------------------------------------------------
// acc_dual_16bit_lane
// One channel of the accumulator: a running accumulator plus the registered
// window-sum output. Window control (first/last decode) comes from the parent.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   take       : accept prod this cycle
//   first      : this term opens a window (seed from bias instead of acc)
//   last       : this term closes a window (publish to sum)
//   prod       : signed 16-bit product
//   bias       : signed seed, only used on the first term
//   sum        : signed window result, held until the next completed window
// -----------------------------------------------------------------------------
module acc_dual_16bit_lane
  import acc_dual_16bit_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        take,
  input  logic                        first,
  input  logic                        last,
  input  logic signed [PROD_WIDTH-1:0] prod,
  input  logic signed [ACC_WIDTH-1:0]  bias,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic signed [ACC_WIDTH-1:0] sum_reg;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;

  // Signed size cast sign-extends; the add then wraps modulo 2^ACC_WIDTH.
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_next = (first ? bias : acc_reg) + prod_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg <= '0;
      sum_reg <= '0;
    end else if (take) begin
      acc_reg <= acc_next;
      if (last) begin
        sum_reg <= acc_next;
      end
    end
  end

  assign sum = sum_reg;

endmodule

// File: rtl/acc_dual_16bit.sv
// -----------------------------------------------------------------------------
// acc_dual_16bit
// Reduction stage for the dual packed 8-bit multiplier: sums NUM_TERMS valid
// products per channel, each window seeded with a per-channel bias, and emits
// both sums with a one-cycle o_valid pulse on the cycle after the last term.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   prod_a, prod_b : signed 16-bit products (channels A/B)
//   i_valid        : products valid this cycle
//   i_clear        : restart the window, discarding any partial sums
//   bias_a, bias_b : signed seeds, sampled on the first term of a window
//   sum_a, sum_b   : signed window results
//   o_valid        : one-cycle pulse, sums are new this cycle
// The window position is carried only by cnt: cnt==0 is the FIRST state,
// 0<cnt<NUM_TERMS is ACCUM.
// -----------------------------------------------------------------------------
module acc_dual_16bit
  import acc_dual_16bit_pkg::*;
#(
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int NUM_TERMS   = DEF_NUM_TERMS,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  // Set to 0 only for builds that deliberately exercise wrap-around.
  parameter bit WIDTH_CHECK = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PROD_WIDTH-1:0] prod_a,
  input  logic signed [PROD_WIDTH-1:0] prod_b,
  input  logic                         i_valid,
  input  logic                         i_clear,
  input  logic signed [ACC_WIDTH-1:0]  bias_a,
  input  logic signed [ACC_WIDTH-1:0]  bias_b,
  output logic signed [ACC_WIDTH-1:0]  sum_a,
  output logic signed [ACC_WIDTH-1:0]  sum_b,
  output logic                         o_valid
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);

  if (NUM_TERMS < 1 || NUM_TERMS > 65535 || (NUM_TERMS - 1) >= (2 ** CNT_WIDTH)) begin : g_terms_err
    $error("acc_dual_16bit: NUM_TERMS out of range for CNT_WIDTH");
  end
  if (WIDTH_CHECK && (ACC_WIDTH < min_acc_width(NUM_TERMS))) begin : g_width_err
    $error("acc_dual_16bit: ACC_WIDTH too small for NUM_TERMS");
  end

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 o_valid_reg;
  logic                 first;
  logic                 last;

  // A clear forces the current term (if any) to open a fresh window, so it can
  // only be the last term when the window is a single term long.
  always_comb begin
    first    = (cnt_reg == '0) || i_clear;
    last     = (NUM_TERMS == 1) || (!i_clear && (cnt_reg == LAST_CNT));
    cnt_next = cnt_reg;
    if (i_valid) begin
      if (last) begin
        cnt_next = '0;
      end else if (first) begin
        cnt_next = CNT_WIDTH'(1);
      end else begin
        cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
    end else if (i_clear) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      o_valid_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      o_valid_reg <= i_valid && last;
    end
  end

  assign o_valid = o_valid_reg;

  // Channels share control and differ only in data.
  logic signed [PROD_WIDTH-1:0] prod_arr [2];
  logic signed [ACC_WIDTH-1:0]  bias_arr [2];
  logic signed [ACC_WIDTH-1:0]  sum_arr  [2];

  assign prod_arr[0] = prod_a;
  assign prod_arr[1] = prod_b;
  assign bias_arr[0] = bias_a;
  assign bias_arr[1] = bias_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    acc_dual_16bit_lane #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .take (i_valid),
      .first(first),
      .last (last),
      .prod (prod_arr[gi]),
      .bias (bias_arr[gi]),
      .sum  (sum_arr[gi])
    );
  end

  assign sum_a = sum_arr[0];
  assign sum_b = sum_arr[1];

endmodule

// File: tb/tb_acc_dual_16bit.sv
// -----------------------------------------------------------------------------
// tb_acc_dual_16bit
// Directed bench for acc_dual_16bit: a default build (24-bit, 9 terms), a
// narrow wrap-around build (17-bit, 3 terms) and a single-term build.
// -----------------------------------------------------------------------------
module tb_acc_dual_16bit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ov_count = 0;
  int ov_base;

  // Default build
  logic signed [15:0] prod_a, prod_b;
  logic               i_valid, i_clear;
  logic signed [23:0] bias_a, bias_b;
  logic signed [23:0] sum_a, sum_b;
  logic               o_valid;

  // Wrap build
  logic signed [15:0] w_prod_a, w_prod_b;
  logic               w_valid;
  logic signed [16:0] w_bias_a, w_bias_b;
  logic signed [16:0] w_sum_a, w_sum_b;
  logic               w_ov;

  // Single-term build
  logic signed [15:0] s_prod_a, s_prod_b;
  logic               s_valid, s_clear;
  logic signed [23:0] s_bias_a, s_bias_b;
  logic signed [23:0] s_sum_a, s_sum_b;
  logic               s_ov;

  acc_dual_16bit #(.ACC_WIDTH(24), .NUM_TERMS(9), .CNT_WIDTH(16), .WIDTH_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .prod_a(prod_a), .prod_b(prod_b),
    .i_valid(i_valid), .i_clear(i_clear), .bias_a(bias_a), .bias_b(bias_b),
    .sum_a(sum_a), .sum_b(sum_b), .o_valid(o_valid)
  );

  acc_dual_16bit #(.ACC_WIDTH(17), .NUM_TERMS(3), .CNT_WIDTH(16), .WIDTH_CHECK(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .prod_a(w_prod_a), .prod_b(w_prod_b),
    .i_valid(w_valid), .i_clear(1'b0), .bias_a(w_bias_a), .bias_b(w_bias_b),
    .sum_a(w_sum_a), .sum_b(w_sum_b), .o_valid(w_ov)
  );

  acc_dual_16bit #(.ACC_WIDTH(24), .NUM_TERMS(1), .CNT_WIDTH(16), .WIDTH_CHECK(1'b1)) dut_one (
    .clk(clk), .rst_n(rst_n), .prod_a(s_prod_a), .prod_b(s_prod_b),
    .i_valid(s_valid), .i_clear(s_clear), .bias_a(s_bias_a), .bias_b(s_bias_b),
    .sum_a(s_sum_a), .sum_b(s_sum_b), .o_valid(s_ov)
  );

  always @(negedge clk) begin
    if (o_valid === 1'b1) ov_count++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus at the falling edge; outputs observed right
  // after this call reflect the previous cycle's inputs.
  task automatic cyc(input logic v, input logic c, input int a, input int b,
                     input int ba, input int bb);
    @(negedge clk);
    i_valid = v;
    i_clear = c;
    prod_a  = 16'(a);
    prod_b  = 16'(b);
    bias_a  = 24'(ba);
    bias_b  = 24'(bb);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 0; i_clear = 0; prod_a = 0; prod_b = 0; bias_a = 0; bias_b = 0;
    w_valid = 0; w_prod_a = 0; w_prod_b = 0; w_bias_a = 0; w_bias_b = 0;
    s_valid = 0; s_clear = 0; s_prod_a = 0; s_prod_b = 0; s_bias_a = 0; s_bias_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_ov", o_valid, 0);
    chk("rst_sum_a", sum_a, 0);
    chk("rst_sum_b", sum_b, 0);
    rst_n = 1'b1;

    // Basic window
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, k, -16384, 100, -5);
      if (k == 9) chk("t1_no_early", o_valid, 0);
    end
    idle();
    chk("t1_ov", o_valid, 1);
    chk("t1_sum_a", sum_a, 145);
    chk("t1_sum_b", sum_b, -147461);
    idle();
    chk("t1_ov_pulse", o_valid, 0);
    chk("t1_hold_a", sum_a, 145);

    // Window with random gaps, then two back-to-back windows
    ov_base = ov_count;
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, k, -16384, 200, 5);
      repeat ($urandom_range(0, 3)) idle();
    end
    idle();
    idle();
    chk("gap_sum_a", sum_a, 245);
    chk("gap_sum_b", sum_b, -147451);
    for (int k = 1; k <= 9; k++) cyc(1, 0, k, k, 100, -5);
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, 2, -1, 10, 0);
      if (k == 1) begin
        chk("b2b_w1_ov", o_valid, 1);
        chk("b2b_w1_a", sum_a, 145);
        chk("b2b_w1_b", sum_b, 40);
      end
      if (k == 2) chk("b2b_w1_pulse", o_valid, 0);
    end
    idle();
    chk("b2b_w2_ov", o_valid, 1);
    chk("b2b_w2_a", sum_a, 28);
    chk("b2b_w2_b", sum_b, -9);
    idle();
    idle();
    chk("b2b_ov_count", ov_count - ov_base, 3);

    // Clear with no valid after 4 of 9 terms
    ov_base = ov_count;
    for (int k = 1; k <= 4; k++) cyc(1, 0, 1, 3, 100, 0);
    cyc(0, 1, 0, 0, 100, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, 1, 3, 7, 0);
      if (k == 6) chk("clr_no_ov", o_valid, 0);
    end
    idle();
    chk("clr_ov", o_valid, 1);
    chk("clr_sum_a", sum_a, 16);
    chk("clr_sum_b", sum_b, 27);
    idle();
    idle();
    chk("clr_ov_count", ov_count - ov_base, 1);

    // Clear together with valid mid-window
    for (int k = 1; k <= 3; k++) cyc(1, 0, 1, 0, 100, -1);
    cyc(1, 1, 50, 0, 0, -1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 1, 0, 0, -1);
      if (k == 8) chk("clrv_no_early", o_valid, 0);
    end
    idle();
    chk("clrv_ov", o_valid, 1);
    chk("clrv_sum_a", sum_a, 58);
    chk("clrv_sum_b", sum_b, -1);

    // Reset for one cycle after 5 terms
    for (int k = 1; k <= 5; k++) cyc(1, 0, 1, 1, 100, 0);
    idle();
    rst_n = 1'b0;
    idle();
    chk("mrst_ov", o_valid, 0);
    chk("mrst_sum_a", sum_a, 0);
    chk("mrst_sum_b", sum_b, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc(1, 0, k, 1, 100, 0);
      if (k == 6) chk("mrst_no_early", o_valid, 0);
    end
    idle();
    chk("mrst_ov_post", o_valid, 1);
    chk("mrst_sum_a2", sum_a, 145);
    chk("mrst_sum_b2", sum_b, 9);

    // Wrap-around build: 17-bit accumulator, 3 terms
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      w_valid = 1; w_prod_a = 16'sd32767; w_prod_b = -16'sd32768; w_bias_a = 0; w_bias_b = 0;
    end
    @(negedge clk);
    w_valid = 0;
    chk("wrap_ov", w_ov, 1);
    chk("wrap_sum_a", w_sum_a, -32771);
    chk("wrap_sum_b", w_sum_b, 32768);

    // Single-term build: every valid completes
    @(negedge clk);
    s_valid = 1; s_bias_a = 5; s_prod_a = 10; s_bias_b = 0; s_prod_b = -7;
    @(negedge clk);
    chk("one_ov1", s_ov, 1);
    chk("one_sum_a1", s_sum_a, 15);
    chk("one_sum_b1", s_sum_b, -7);
    s_bias_a = -3; s_prod_a = -20; s_bias_b = 1; s_prod_b = 100;
    @(negedge clk);
    chk("one_ov2", s_ov, 1);
    chk("one_sum_a2", s_sum_a, -23);
    chk("one_sum_b2", s_sum_b, 101);
    s_clear = 1; s_bias_a = 1; s_prod_a = 1;
    @(negedge clk);
    s_valid = 0; s_clear = 0;
    chk("one_clrv_ov", s_ov, 1);
    chk("one_clrv_a", s_sum_a, 2);
    @(negedge clk);
    chk("one_idle_ov", s_ov, 0);
    chk("one_hold_a", s_sum_a, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_dual_16bit.md
Name: acc_dual_16bit

Overview:
- Downstream consumer of the dual packed 8-bit multiplier.
- Takes the two signed 16-bit product streams (prod_ac, prod_bc) and their valid, and accumulates NUM_TERMS products per channel into two wide accumulators.
- Each window is seeded with a per-channel bias.
- Emits both window sums with a one-cycle valid pulse, forming the reduction stage of a conv/dot-product lane.

Parameters:
- ACC_WIDTH, 24, width of accumulators and sum outputs (signed); must be >= 16 + ceil(log2(NUM_TERMS+1)).
- NUM_TERMS, 9, number of valid products summed per output window; legal range 1..65535.
- CNT_WIDTH, 16, width of the internal term counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- prod_a  input  16  signed product, channel A (from prod_ac).
- prod_b  input  16  signed product, channel B (from prod_bc).
- i_valid  input  1  products valid this cycle.
- i_clear  input  1  synchronous window restart; discards the partial window.
- bias_a  input  ACC_WIDTH  signed seed for channel A, sampled on the first term of each window.
- bias_b  input  ACC_WIDTH  signed seed for channel B, sampled on the first term of each window.
- sum_a  output  ACC_WIDTH  signed window result, channel A.
- sum_b  output  ACC_WIDTH  signed window result, channel B.
- o_valid  output  1  one-cycle pulse; sum_a/sum_b are new this cycle.

Behaviour:
- Reset:
  - rst_n is synchronous active-low, sampled on posedge clk.
  - While low: cnt=0, acc_a=acc_b=0, sum_a=sum_b=0, o_valid=0.
  - Reset mid-window discards all partial sums; the first i_valid after release starts a new window.
- States, encoded by cnt:
  - FIRST (cnt==0).
  - ACCUM (0<cnt<NUM_TERMS).
  - No separate FSM register.
- Products are sign-extended to ACC_WIDTH before any add.
- All adds wrap modulo 2^ACC_WIDTH (two's complement, no saturation).
- Per cycle with i_valid=1 and i_clear=0:
  - FIRST: acc <= bias + prod; cnt <= 1.
  - ACCUM: acc <= acc + prod; cnt <= cnt+1.
  - Last term (cnt==NUM_TERMS-1, or NUM_TERMS==1 in FIRST): sum <= (cnt==0 ? bias : acc) + prod; o_valid <= 1; cnt <= 0. The acc value after the last term is don't-care.
- i_valid=0: acc and cnt hold; gaps of any length inside a window are legal.
- o_valid is high for exactly one cycle per completed window, else 0.
- sum_a/sum_b hold their last value until the next o_valid.
- Latency: the sum appears, with o_valid, on the cycle after the last term is accepted.
- Back-to-back windows: a last term at cycle N and a first term at cycle N+1 are both accepted with no bubble.
- i_clear=1:
  - cnt <= 0; any partial window is discarded; no o_valid for it.
  - If i_valid is also 1, that product becomes the first term of the new window, with bias sampled that cycle. If NUM_TERMS==1, it completes immediately.
  - i_clear never suppresses an o_valid already registered from the prior cycle.
- Channels A and B are fully independent in data and share cnt/valid control.
- No backpressure. The downstream stage must accept every o_valid pulse.

Decomposition:
- Shared package holds:
  - the default ACC_WIDTH/NUM_TERMS constants;
  - a localparam function computing the minimum safe ACC_WIDTH (clog2-based), used by a static width check at elaboration.
- One natural sub-module: acc_lane, one channel's accumulator plus sum register, instantiated twice. Control (cnt, first/last decode, o_valid) lives in the parent.

Test Plan:
- NUM_TERMS=9, bias_a=100, bias_b=-5, nine valid cycles with prod_a=+1..+9 and prod_b=-128*… (all -16384) -> one cycle after the 9th: sum_a=145, sum_b=-147461, o_valid pulse exactly 1 cycle.
- Same windows with random 0-3 cycle gaps between terms, then back-to-back windows with no gaps -> identical sums; o_valid count equals window count; no lost term across the window boundary.
- Wrap check, ACC_WIDTH=17, NUM_TERMS=3, bias=0, prod_a=32767 x3 -> sum_a = 98301 mod 2^17 interpreted signed = -32771.
- i_clear after 4 of 9 terms, with i_valid=0 -> no o_valid. The next 9 terms with bias_a=7, prod_a=1 -> sum_a=16.
- i_clear and i_valid together mid-window (prod_a=50, bias_a=0), then 8 more terms of 1 -> sum_a=58.
- rst_n low for 1 cycle after 5 terms -> outputs 0 next cycle. A full 9-term window after release sums correctly. NUM_TERMS=1 build: each valid yields bias+prod next cycle.
